spmv_mem_req_arb: RTL and testbench
===================================

Name: spmv_mem_req_arb

Overview:
- Parametrised N-channel memory request arbiter and response router for the SpMV processing element.
- Merges load/store requests from NUM_CH request FIFOs (decoder, x-vector cache, MAC writeback, ...) into the single memory port through an internal queue that honours a registered stall.
- Fixed-priority or round-robin mode.
- Encodes the source channel in the load tag and routes load responses back to the originating channel.
- Tracks outstanding loads for PE busy/steady-state detection.

Parameters:
- NUM_CH, 3, number of request channels (2..8); CH_W = max(1, clog2(NUM_CH)) is a localparam.
- ADDR_W, 48, request address width.
- DATA_W, 64, store data / response data width.
- TAG_W, 3, memory tag width; low CH_W bits = channel id, upper UTAG_W = TAG_W-CH_W bits = user tag (UTAG_W >= 1 required).
- DEPTH, 32, internal request queue depth (power of 2).
- ALMOST_FULL_COUNT, 4, arbitration headroom.
- MODE, 0, 0 = fixed priority (channel 0 highest), 1 = round robin.
- OUTST_W, 16, outstanding-load counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  NUM_CH  channel FIFO non-empty.
- in_pop  out  NUM_CH  combinational grant/pop to channel FIFO; at most one bit set.
- in_st  in  NUM_CH  head is store (1) or load (0); sampled 1 cycle after pop.
- in_addr  in  NUM_CH*ADDR_W  head address; sampled 1 cycle after pop.
- in_d  in  NUM_CH*DATA_W  store data; sampled 1 cycle after pop.
- in_utag  in  NUM_CH*UTAG_W  load user tag; sampled 1 cycle after pop.
- req_mem_ld  out  1  memory load strobe.
- req_mem_st  out  1  memory store strobe.
- req_mem_addr  out  ADDR_W  memory address.
- req_mem_d_or_tag  out  DATA_W  store data, or load tag in [TAG_W-1:0] with upper bits zero.
- req_mem_stall  in  1  memory backpressure.
- rsp_mem_push  in  1  memory response valid.
- rsp_mem_tag  in  TAG_W  response tag.
- rsp_mem_q  in  DATA_W  response data.
- rsp_mem_stall  out  1  response backpressure.
- out_rsp_push  out  NUM_CH  per-channel response strobe.
- out_rsp_utag  out  UTAG_W  routed user tag.
- out_rsp_q  out  DATA_W  routed data.
- out_rsp_stall  in  NUM_CH  per-channel response backpressure.
- outstanding  out  OUTST_W  loads issued and not yet answered.
- busy  out  1  activity in flight.
- rsp_err  out  1  sticky bad-channel response.

Behaviour:
- Reset: all outputs 0; queue empty; round-robin pointer = NUM_CH-1 (first grant goes to channel 0); all pipeline registers cleared.
- Reset mid-operation: queued requests and in-flight pops are discarded; counters cleared.
- Grant is blocked when queue count + in-flight pops >= DEPTH-ALMOST_FULL_COUNT.
- Otherwise, MODE 0 grants the lowest-index valid channel.
- MODE 1 searches from pointer+1 with wrap modulo NUM_CH; the pointer updates to the granted channel only on a grant.
- Capture stage: the cycle after in_pop[c], the selected in_* fields are registered as {st, addr, d_or_tag} and pushed into the queue the following cycle (grant to enqueue = 2 cycles).
- Load tag = {utag, c[CH_W-1:0]}.
- Queue pop condition: !empty && !req_mem_stall_r, where req_mem_stall_r is req_mem_stall delayed 1 cycle.
- Output registers load the popped entry on the next edge; req_mem_ld/st are 0 in any cycle without a pop.
- Minimum grant-to-memory latency is 4 cycles.
- Simultaneous push and pop keep the queue count unchanged.
- Overflow is impossible by the headroom rule; a push while full is an assertion failure.
- outstanding: +1 on each issued req_mem_ld, -1 on each rsp_mem_push; both in the same cycle leaves it unchanged.
- outstanding saturates at 0 on decrement and at all-ones on increment.
- Response path: inputs registered once. The cycle after, out_rsp_push[ch] = registered push, out_rsp_utag = tag[TAG_W-1:CH_W], out_rsp_q = data.
- A channel id >= NUM_CH suppresses the push, sets rsp_err (cleared only by rst) and still decrements outstanding.
- rsp_mem_stall = registered OR of out_rsp_stall.
- busy = queue non-empty || in-flight pop/capture || output strobe || outstanding != 0; registered.

Test Plan:
- MODE 0, all 3 channels valid continuously, stall low -> grants 0,0,0... only; ch1 granted the first cycle ch0 drops valid.
- MODE 1, 3 channels valid -> grant sequence 0,1,2,0,1,2; ch1 invalid -> 0,2,0,2.
- Single load on ch2, utag=1, addr 0x1000 -> 4 cycles later req_mem_ld=1, addr 0x1000, d_or_tag=3'b110; outstanding=1.
- Response tag 3'b110, q=0xDEAD -> 2 cycles later out_rsp_push=3'b100, utag=1, q=0xDEAD; outstanding=0, busy falls.
- req_mem_stall held high for 40 cycles with all channels valid -> queue count peaks at DEPTH-ALMOST_FULL_COUNT=28; no loss; after release 28 ordered requests, one per cycle.
- Response with tag channel 3 (NUM_CH=3) -> no out_rsp_push, rsp_err=1 until rst; rst asserted mid-burst -> outputs 0 asynchronously, queue empty.

Source files
------------

// File: rtl/spmv_mem_req_arb.sv
// spmv_mem_req_arb: N-channel memory request arbiter with load-tag response routing
module spmv_mem_req_arb #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 48,
    parameter int DATA_W = 64,
    parameter int TAG_W = 3,
    parameter int DEPTH = 32,
    parameter int ALMOST_FULL_COUNT = 4,
    parameter int MODE = 0,
    parameter int OUTST_W = 16,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int UTAG_W = TAG_W - CH_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_pop,
    input  logic [NUM_CH-1:0]          in_st,
    input  logic [NUM_CH*ADDR_W-1:0]   in_addr,
    input  logic [NUM_CH*DATA_W-1:0]   in_d,
    input  logic [NUM_CH*UTAG_W-1:0]   in_utag,
    output logic                       req_mem_ld,
    output logic                       req_mem_st,
    output logic [ADDR_W-1:0]          req_mem_addr,
    output logic [DATA_W-1:0]          req_mem_d_or_tag,
    input  logic                       req_mem_stall,
    input  logic                       rsp_mem_push,
    input  logic [TAG_W-1:0]           rsp_mem_tag,
    input  logic [DATA_W-1:0]          rsp_mem_q,
    output logic                       rsp_mem_stall,
    output logic [NUM_CH-1:0]          out_rsp_push,
    output logic [UTAG_W-1:0]          out_rsp_utag,
    output logic [DATA_W-1:0]          out_rsp_q,
    input  logic [NUM_CH-1:0]          out_rsp_stall,
    output logic [OUTST_W-1:0]         outstanding,
    output logic                       busy,
    output logic                       rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + ADDR_W + DATA_W;

    logic [EW-1:0]      r_mem [DEPTH];
    logic [AW-1:0]      r_wp, r_rp;
    logic [AW:0]        r_cnt;
    logic               r_pop_v, r_cap_v, r_stall;
    logic [CH_W-1:0]    r_pop_ch, r_ptr;
    logic [EW-1:0]      r_cap;
    logic               r_ld, r_st;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_d;
    logic [OUTST_W-1:0] r_out;
    logic               r_rp_v, r_busy, r_err, r_rstall;
    logic [TAG_W-1:0]   r_rp_tag;
    logic [DATA_W-1:0]  r_rp_q, r_oq;
    logic [NUM_CH-1:0]  r_opush;
    logic [UTAG_W-1:0]  r_outag;
    logic               w_any, w_gnt, w_block, w_empty, w_full, w_pop, w_inc, w_bad;
    logic [CH_W-1:0]    w_ch;
    logic [EW-1:0]      w_head;

    assign w_empty = r_cnt == '0;
    assign w_full  = r_cnt == (AW+1)'(DEPTH);
    assign w_pop   = !w_empty && !r_stall;
    assign w_head  = r_mem[r_rp];
    assign w_inc   = w_pop && !w_head[EW-1];
    assign w_block = ({1'b0, r_cnt} + (AW+2)'(r_pop_v) + (AW+2)'(r_cap_v)) >= (AW+2)'(DEPTH - ALMOST_FULL_COUNT);
    assign w_gnt   = w_any && !w_block;
    assign w_bad   = int'(r_rp_tag[CH_W-1:0]) >= NUM_CH;

    // pick the winning channel: lowest index, or first valid after the round-robin pointer
    always_comb begin
        w_any = 1'b0;
        w_ch = '0;
        for (int k = NUM_CH; k >= 1; k--)
            if (in_valid[(MODE == 1 ? int'(r_ptr) + k : k - 1) % NUM_CH]) begin
                w_any = 1'b1;
                w_ch = CH_W'((MODE == 1 ? int'(r_ptr) + k : k - 1) % NUM_CH);
            end
    end

    assign in_pop = (w_gnt && !rst) ? NUM_CH'(1) << w_ch : '0;

    // grant pipeline: remember the popped channel, then capture its head fields a cycle later
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_pop_v <= 1'b0;
            r_pop_ch <= '0;
            r_cap_v <= 1'b0;
            r_cap <= '0;
            r_ptr <= CH_W'(NUM_CH - 1);
        end else begin
            r_pop_v <= w_gnt;
            r_pop_ch <= w_ch;
            r_cap_v <= r_pop_v;
            r_cap <= {in_st[r_pop_ch], in_addr[r_pop_ch*ADDR_W +: ADDR_W],
                      in_st[r_pop_ch] ? in_d[r_pop_ch*DATA_W +: DATA_W]
                                      : DATA_W'({in_utag[r_pop_ch*UTAG_W +: UTAG_W], r_pop_ch})};
            if (w_gnt) r_ptr <= w_ch;
        end

    // queue storage needs no reset; only the pointers define its contents
    always_ff @(posedge clk)
        if (r_cap_v) r_mem[r_wp] <= r_cap;

    // queue pointers, occupancy and the delayed memory stall
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
            r_stall <= 1'b0;
        end else begin
            r_wp <= r_wp + AW'(r_cap_v);
            r_rp <= r_rp + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(r_cap_v) - (AW+1)'(w_pop);
            r_stall <= req_mem_stall;
        end

    // memory port registers load the dequeued entry; strobes only on a dequeue
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_ld <= 1'b0;
            r_st <= 1'b0;
            r_addr <= '0;
            r_d <= '0;
        end else begin
            r_ld <= w_inc;
            r_st <= w_pop && w_head[EW-1];
            if (w_pop) {r_addr, r_d} <= w_head[EW-2:0];
        end

    // saturating count of loads issued but not yet answered
    always_ff @(posedge clk or posedge rst)
        if (rst) r_out <= '0;
        else if (w_inc && !rsp_mem_push && !(&r_out)) r_out <= r_out + 1'b1;
        else if (rsp_mem_push && !w_inc && |r_out) r_out <= r_out - 1'b1;

    // response path: register inputs, then route to the channel named in the tag
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_rp_v <= 1'b0;
            r_rp_tag <= '0;
            r_rp_q <= '0;
            r_opush <= '0;
            r_outag <= '0;
            r_oq <= '0;
            r_err <= 1'b0;
            r_rstall <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_rp_v <= rsp_mem_push;
            r_rp_tag <= rsp_mem_tag;
            r_rp_q <= rsp_mem_q;
            r_opush <= (r_rp_v && !w_bad) ? NUM_CH'(1) << r_rp_tag[CH_W-1:0] : '0;
            r_outag <= r_rp_tag[TAG_W-1:CH_W];
            r_oq <= r_rp_q;
            r_err <= r_err || (r_rp_v && w_bad);
            r_rstall <= |out_rsp_stall;
            r_busy <= !w_empty || r_pop_v || r_cap_v || r_ld || r_st || r_out != '0;
        end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(r_cap_v && w_full));

    assign req_mem_ld = r_ld;
    assign req_mem_st = r_st;
    assign req_mem_addr = r_addr;
    assign req_mem_d_or_tag = r_d;
    assign rsp_mem_stall = r_rstall;
    assign out_rsp_push = r_opush;
    assign out_rsp_utag = r_outag;
    assign out_rsp_q = r_oq;
    assign outstanding = r_out;
    assign busy = r_busy;
    assign rsp_err = r_err;
endmodule

// File: tb/tb_spmv_mem_req_arb.sv
// tb_spmv_mem_req_arb: scoreboard bench for the SpMV memory request arbiter
module tb_spmv_mem_req_arb;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] in_valid, in_st = '0, in_utag = '0, rsp_mem_tag = '0, out_rsp_stall = '0;
    logic [143:0] in_addr = '0;
    logic [191:0] in_d = '0;
    logic req_mem_stall = 1'b0, rsp_mem_push = 1'b0;
    logic [63:0] rsp_mem_q = '0;
    logic [2:0] in_pop, out_rsp_push, u1_in_pop, u1_out_rsp_push;
    logic req_mem_ld, req_mem_st, rsp_mem_stall, busy, rsp_err, out_rsp_utag;
    logic u1_req_mem_ld, u1_req_mem_st, u1_rsp_mem_stall, u1_busy, u1_rsp_err, u1_out_rsp_utag;
    logic [47:0] req_mem_addr, u1_req_mem_addr;
    logic [63:0] req_mem_d_or_tag, out_rsp_q, u1_req_mem_d_or_tag, u1_out_rsp_q;
    logic [15:0] outstanding, u1_outstanding;

    int errors = 0, checks = 0;
    int lim [3] = '{0, 0, 0};
    int served [3] = '{0, 0, 0};
    logic sel = 1'b0;
    logic [2:0] ovr_en = '0;
    logic ovr_st = 1'b0, ovr_utag = 1'b0;
    logic [47:0] ovr_addr = '0;
    logic [112:0] exp_q [$];
    logic [67:0] rsp_q [$];

    always #5 clk = ~clk;

    always_comb
        for (int c = 0; c < 3; c++) in_valid[c] = lim[c] < 0 || served[c] < lim[c];

    spmv_mem_req_arb #(.MODE(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pop(in_pop), .in_st(in_st),
        .in_addr(in_addr), .in_d(in_d), .in_utag(in_utag), .req_mem_ld(req_mem_ld),
        .req_mem_st(req_mem_st), .req_mem_addr(req_mem_addr), .req_mem_d_or_tag(req_mem_d_or_tag),
        .req_mem_stall(req_mem_stall), .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag),
        .rsp_mem_q(rsp_mem_q), .rsp_mem_stall(rsp_mem_stall), .out_rsp_push(out_rsp_push),
        .out_rsp_utag(out_rsp_utag), .out_rsp_q(out_rsp_q), .out_rsp_stall(out_rsp_stall),
        .outstanding(outstanding), .busy(busy), .rsp_err(rsp_err));

    spmv_mem_req_arb #(.MODE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pop(u1_in_pop), .in_st(in_st),
        .in_addr(in_addr), .in_d(in_d), .in_utag(in_utag), .req_mem_ld(u1_req_mem_ld),
        .req_mem_st(u1_req_mem_st), .req_mem_addr(u1_req_mem_addr), .req_mem_d_or_tag(u1_req_mem_d_or_tag),
        .req_mem_stall(req_mem_stall), .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag),
        .rsp_mem_q(rsp_mem_q), .rsp_mem_stall(u1_rsp_mem_stall), .out_rsp_push(u1_out_rsp_push),
        .out_rsp_utag(u1_out_rsp_utag), .out_rsp_q(u1_out_rsp_q), .out_rsp_stall(out_rsp_stall),
        .outstanding(u1_outstanding), .busy(u1_busy), .rsp_err(u1_rsp_err));

    wire m_ld = sel ? u1_req_mem_ld : req_mem_ld;
    wire m_st = sel ? u1_req_mem_st : req_mem_st;
    wire [47:0] m_addr = sel ? u1_req_mem_addr : req_mem_addr;
    wire [63:0] m_d = sel ? u1_req_mem_d_or_tag : req_mem_d_or_tag;

    // channel FIFO model: a pop hands over its head next cycle and books the expected request
    initial begin
        logic [2:0] pend;
        logic sv, uv;
        logic [47:0] av;
        logic [63:0] dv;
        forever begin
            @(negedge clk);
            #2 pend = sel ? u1_in_pop : in_pop;
            @(posedge clk);
            #1;
            for (int c = 0; c < 3; c++)
                if (pend[c]) begin
                    sv = ovr_en[c] ? ovr_st : 1'((served[c] + c) & 1);
                    av = ovr_en[c] ? ovr_addr : 48'(c * 32'h10000 + served[c] * 8);
                    uv = ovr_en[c] ? ovr_utag : 1'((served[c] >> 1) & 1);
                    dv = 64'(32'h0100_0000 * (c + 1) + served[c]);
                    in_st[c] = sv;
                    in_addr[c*48 +: 48] = av;
                    in_d[c*64 +: 64] = dv;
                    in_utag[c] = uv;
                    exp_q.push_back({sv, av, sv ? dv : {61'b0, uv, 2'(c)}});
                    served[c]++;
                end
        end
    end

    // output monitor: every memory strobe and routed response must match the scoreboards
    initial begin
        logic [112:0] e;
        logic [67:0] r;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                exp_q.delete();
                rsp_q.delete();
            end else begin
                if (m_ld || m_st) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_req_unexpected: got ld=%0b st=%0b addr=%h d=%h, expected no request", m_ld, m_st, m_addr, m_d);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_ld, m_st, m_addr, m_d} !== {~e[112], e}) begin
                            errors++;
                            $display("FAIL mem_req: got ld=%0b st=%0b addr=%h d=%h, expected st=%0b addr=%h d=%h", m_ld, m_st, m_addr, m_d, e[112], e[111:64], e[63:0]);
                        end
                    end
                end
                if (out_rsp_push != 0) begin
                    checks++;
                    if (rsp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: got push=%b utag=%0b q=%h, expected none", out_rsp_push, out_rsp_utag, out_rsp_q);
                    end else begin
                        r = rsp_q.pop_front();
                        if ({out_rsp_push, out_rsp_utag, out_rsp_q} !== r) begin
                            errors++;
                            $display("FAIL rsp_route: got push=%b utag=%0b q=%h, expected push=%b utag=%0b q=%h", out_rsp_push, out_rsp_utag, out_rsp_q, r[67:65], r[64], r[63:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic stop_all();
        for (int c = 0; c < 3; c++) lim[c] = served[c];
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) lim[c] = -1;
        out_rsp_stall = 3'b111;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({in_pop, u1_in_pop} !== 6'b0) begin
            errors++;
            $display("FAIL reset_pop: got %b/%b, expected 000/000", in_pop, u1_in_pop);
        end
        checks++;
        if ({req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag} !== '0) begin
            errors++;
            $display("FAIL reset_mem: got ld=%0b st=%0b addr=%h d=%h, expected all 0", req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag);
        end
        checks++;
        if ({rsp_mem_stall, out_rsp_push, out_rsp_utag, out_rsp_q, outstanding, busy, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_misc: got stall=%0b push=%b utag=%0b q=%h outst=%0d busy=%0b err=%0b, expected all 0", rsp_mem_stall, out_rsp_push, out_rsp_utag, out_rsp_q, outstanding, busy, rsp_err);
        end
        stop_all();
        out_rsp_stall = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rsp_stall();
        @(negedge clk);
        out_rsp_stall = 3'b010;
        #1;
        checks++;
        if (rsp_mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL rsp_stall_early: got %0b, expected 0", rsp_mem_stall);
        end
        @(negedge clk);
        checks++;
        if (rsp_mem_stall !== 1'b1) begin
            errors++;
            $display("FAIL rsp_stall_set: got %0b, expected 1", rsp_mem_stall);
        end
        out_rsp_stall = '0;
        @(negedge clk);
        checks++;
        if (rsp_mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL rsp_stall_clr: got %0b, expected 0", rsp_mem_stall);
        end
    endtask

    task automatic test_fixed_priority();
        sel = 1'b0;
        reset_dut();
        @(negedge clk);
        for (int c = 0; c < 3; c++) lim[c] = -1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (in_pop !== 3'b001) begin
                errors++;
                $display("FAIL fixed_grant[%0d]: got %b, expected 001", i, in_pop);
            end
        end
        @(negedge clk);
        lim[0] = served[0];
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (in_pop !== 3'b010) begin
                errors++;
                $display("FAIL fixed_ch0_drop[%0d]: got %b, expected 010", i, in_pop);
            end
        end
        @(negedge clk);
        stop_all();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [2:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        sel = 1'b1;
        reset_dut();
        @(negedge clk);
        for (int c = 0; c < 3; c++) lim[c] = -1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (u1_in_pop !== seq[i]) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b, expected %b", i, u1_in_pop, seq[i]);
            end
        end
        @(negedge clk);
        lim[1] = served[1];
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (u1_in_pop !== ((i % 2) ? 3'b100 : 3'b001)) begin
                errors++;
                $display("FAIL rr_skip_ch1[%0d]: got %b, expected %b", i, u1_in_pop, (i % 2) ? 3'b100 : 3'b001);
            end
        end
        @(negedge clk);
        stop_all();
        repeat (10) @(negedge clk);
        reset_dut();
        sel = 1'b0;
    endtask

    task automatic test_single_load();
        reset_dut();
        ovr_en = 3'b100;
        ovr_st = 1'b0;
        ovr_addr = 48'h1000;
        ovr_utag = 1'b1;
        @(negedge clk);
        lim[2] = served[2] + 1;
        #1;
        checks++;
        if (in_pop !== 3'b100) begin
            errors++;
            $display("FAIL single_grant: got %b, expected 100", in_pop);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (req_mem_ld !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got ld=%0b at 3 cycles, expected 0", req_mem_ld);
        end
        @(negedge clk);
        checks++;
        if ({req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag, outstanding, busy} !== {1'b1, 1'b0, 48'h1000, 64'h6, 16'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_load: got ld=%0b st=%0b addr=%h tag=%h outst=%0d busy=%0b, expected 1 0 1000 6 1 1", req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag, outstanding, busy);
        end
        @(negedge clk);
        ovr_en = '0;
        checks++;
        if ({req_mem_ld, outstanding} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL single_after: got ld=%0b outst=%0d, expected 0 1", req_mem_ld, outstanding);
        end
        rsp_mem_push = 1'b1;
        rsp_mem_tag = 3'b110;
        rsp_mem_q = 64'hDEAD;
        rsp_q.push_back({3'b100, 1'b1, 64'hDEAD});
        @(negedge clk);
        rsp_mem_push = 1'b0;
        checks++;
        if (out_rsp_push !== 3'b000) begin
            errors++;
            $display("FAIL rsp_early: got %b, expected 000", out_rsp_push);
        end
        @(negedge clk);
        checks++;
        if ({out_rsp_push, out_rsp_utag, out_rsp_q, outstanding, busy} !== {3'b100, 1'b1, 64'hDEAD, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL rsp_deliver: got push=%b utag=%0b q=%h outst=%0d busy=%0b, expected 100 1 dead 0 0", out_rsp_push, out_rsp_utag, out_rsp_q, outstanding, busy);
        end
        @(negedge clk);
        checks++;
        if (out_rsp_push !== 3'b000) begin
            errors++;
            $display("FAIL rsp_once: got %b, expected 000", out_rsp_push);
        end
    endtask

    task automatic test_bad_channel();
        ovr_en = 3'b001;
        ovr_st = 1'b0;
        ovr_utag = 1'b0;
        @(negedge clk);
        lim[0] = served[0] + 1;
        repeat (6) @(negedge clk);
        ovr_en = '0;
        checks++;
        if (outstanding !== 16'd1) begin
            errors++;
            $display("FAIL bad_pre_outst: got %0d, expected 1", outstanding);
        end
        for (int i = 0; i < 2; i++) begin
            rsp_mem_push = 1'b1;
            rsp_mem_tag = 3'b011;
            rsp_mem_q = 64'hBAD;
            @(negedge clk);
            rsp_mem_push = 1'b0;
            @(negedge clk);
            checks++;
            if ({out_rsp_push, rsp_err, outstanding} !== {3'b000, 1'b1, 16'd0}) begin
                errors++;
                $display("FAIL bad_rsp[%0d]: got push=%b err=%0b outst=%0d, expected 000 1 0", i, out_rsp_push, rsp_err, outstanding);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_sticky: got %0b, expected 1", rsp_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0, seen = 0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) lim[c] = -1;
        while (!(req_mem_ld || req_mem_st) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(req_mem_ld || req_mem_st)) begin
            errors++;
            $display("FAIL burst_start: got no strobe in 20 cycles, expected a strobe");
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({req_mem_ld, req_mem_st, in_pop, rsp_err, outstanding, busy} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got ld=%0b st=%0b pop=%b err=%0b outst=%0d busy=%0b, expected all 0", req_mem_ld, req_mem_st, in_pop, rsp_err, outstanding, busy);
        end
        stop_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_mem_ld || req_mem_st) seen++;
        end
        checks++;
        if (seen !== 0 || dut.r_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset_flush: got %0d strobes, count %0d, expected 0 0", seen, dut.r_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int peak = 0, n = 0, run = 0;
        reset_dut();
        @(negedge clk);
        req_mem_stall = 1'b1;
        for (int c = 0; c < 3; c++) lim[c] = -1;
        repeat (40) begin
            @(negedge clk);
            if (int'(dut.r_cnt) > peak) peak = int'(dut.r_cnt);
        end
        #1;
        checks++;
        if (peak !== 28 || in_pop !== 3'b000 || exp_q.size() !== 28) begin
            errors++;
            $display("FAIL stall_fill: got peak=%0d pop=%b grants=%0d, expected 28 000 28", peak, in_pop, exp_q.size());
        end
        stop_all();
        @(negedge clk);
        req_mem_stall = 1'b0;
        while (!(req_mem_ld || req_mem_st) && n < 20) begin
            @(negedge clk);
            n++;
        end
        while ((req_mem_ld || req_mem_st) && run < 100) begin
            run++;
            @(negedge clk);
        end
        #4;
        checks++;
        if (run !== 28 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL stall_drain: got %0d consecutive, %0d left, expected 28 0", run, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_rsp_stall();
        test_fixed_priority();
        test_round_robin();
        test_single_load();
        test_bad_channel();
        test_reset_mid_burst();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
